// File: rtl/regs_seq_pkg.sv
// Shared definitions for the register-file operation sequencer:
// op codes, FSM state encoding and default widths.
package regs_seq_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOR = 3'd5;
  localparam logic [2:0] OP_SLT = 3'd6;
  localparam logic [2:0] OP_LDI = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu32.sv
// Combinational ALU for the sequencer. For LDI the caller routes the
// immediate onto b and the ALU passes it through.
module alu32
  import regs_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] y,
  output logic              zero,
  output logic              ovf
);

  always_comb begin
    y   = '0;
    ovf = 1'b0;
    case (op)
      OP_ADD: begin
        y   = a + b;
        ovf = (a[DATA_W-1] == b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        y   = a - b;
        ovf = (a[DATA_W-1] != b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOR: y = ~(a | b);
      // true signed compare, immune to overflow of a - b
      OP_SLT: y = ($signed(a) < $signed(b)) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
      OP_LDI: y = b;
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/regs_op_sequencer.sv
// Client-side controller for the 8x32 2R/1W register file: accepts an
// instruction, reads operands, runs the ALU and writes the result back.
//
//   state  | meaning
//   S_IDLE | waiting for an instruction, inst_ready=1
//   S_EXEC | operands on read ports, ALU result registered at end of cycle
//   S_WB   | write-back (rf_we, res_valid); can accept the next instruction
module regs_op_sequencer
  import regs_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              cr,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [2:0]        inst_op,
  input  logic [ADDR_W-1:0] inst_rd,
  input  logic [ADDR_W-1:0] inst_rs,
  input  logic [ADDR_W-1:0] inst_rt,
  input  logic [DATA_W-1:0] inst_imm,
  output logic [ADDR_W-1:0] rf_addr_a,
  output logic [ADDR_W-1:0] rf_addr_b,
  input  logic [DATA_W-1:0] rf_qa,
  input  logic [DATA_W-1:0] rf_qb,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr_w,
  output logic [DATA_W-1:0] rf_di,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_zero,
  output logic              res_ovf
);

  seq_state_t        state_q, state_d;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q, rs_q, rt_q;
  logic [DATA_W-1:0] imm_q;
  logic              accept;
  logic [DATA_W-1:0] alu_b, alu_y;
  logic              alu_zero, alu_ovf;

  assign accept = inst_valid && inst_ready;

  always_ff @(posedge clk) begin
    if (cr) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = accept ? S_EXEC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Reset gating is combinational so a pending write is suppressed in the
  // very cycle cr is raised.
  always_comb begin
    inst_ready = 1'b0;
    rf_we      = 1'b0;
    res_valid  = 1'b0;
    rf_addr_w  = '0;
    rf_di      = '0;
    rf_addr_a  = (op_q == OP_LDI) ? '0 : rs_q;
    rf_addr_b  = (op_q == OP_LDI) ? '0 : rt_q;
    if (!cr) begin
      inst_ready = (state_q == S_IDLE) || (state_q == S_WB);
      if (state_q == S_WB) begin
        rf_we     = 1'b1;
        res_valid = 1'b1;
        rf_addr_w = rd_q;
        rf_di     = res_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cr) begin
      op_q  <= OP_ADD;
      rd_q  <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      imm_q <= '0;
    end else if (accept) begin
      op_q  <= inst_op;
      rd_q  <= inst_rd;
      rs_q  <= inst_rs;
      rt_q  <= inst_rt;
      imm_q <= inst_imm;
    end
  end

  assign alu_b = (op_q == OP_LDI) ? imm_q : rf_qb;

  alu32 #(.DATA_W(DATA_W)) u_alu (
    .a    (rf_qa),
    .b    (alu_b),
    .op   (op_q),
    .y    (alu_y),
    .zero (alu_zero),
    .ovf  (alu_ovf)
  );

  always_ff @(posedge clk) begin
    if (cr) begin
      res_data <= '0;
      res_zero <= 1'b1;
      res_ovf  <= 1'b0;
    end else if (state_q == S_EXEC) begin
      res_data <= alu_y;
      res_zero <= alu_zero;
      res_ovf  <= alu_ovf;
    end
  end

endmodule
